mul_approx_cfg_ctrl: RTL
========================

Name: mul_approx_cfg_ctrl

Overview:
Configuration sequencer for the systolic array's approximate signed multipliers. Accepts precision/approximation requests over a valid/ready handshake and decodes them into res_mask/appr_mask. Changes are applied only at a safe tile boundary, after draining in-flight MACs, so every product in a tile uses one consistent configuration. Drives the mask inputs of every mul_8x8_signed_bw instance and stalls the array feeder during a switch.

Parameters:
MAC_OUT_WIDTH, 16, multiplier result width
N_BIT_RES, 12, res_mask width (MAC_OUT_WIDTH-4)
N_BIT_APPR, 8, appr_mask width
PIPE_DEPTH, 3, array cycles needed to drain in-flight products (0 allowed)
PREC_W, 5, width of precision request field
APPR_W, 4, width of approximation request field

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_cfg_valid  in  1  request valid
o_cfg_ready  out  1  request accepted when valid&ready
i_cfg_prec  in  PREC_W  result precision P in bits; legal 4..16
i_cfg_appr  in  APPR_W  truncated LSB columns A; legal 0..8
i_tile_last  in  1  pulse: current tile's last operand issued
i_array_idle  in  1  array holds no tile
i_cfg_flush  in  1  sync abort of a pending request
o_res_mask  out  N_BIT_RES  to multipliers
o_appr_mask  out  N_BIT_APPR  to multipliers
o_stall  out  1  hold array feeder
o_busy  out  1  FSM not in IDLE
o_cfg_applied  out  1  one-cycle pulse when new masks take effect
o_cfg_err  out  1  one-cycle pulse on illegal request
o_cur_prec  out  PREC_W  active P
o_cur_appr  out  APPR_W  active A
o_applied_cnt  out  16  see Optional Feature
o_err_cnt  out  16  see Optional Feature

Behaviour:
- Reset (async): IDLE; o_res_mask all ones; o_appr_mask all ones; o_cur_prec=16; o_cur_appr=0; o_stall, o_busy, o_cfg_applied, o_cfg_err = 0; counters = 0.
- Decode: res_mask[k]=1 iff k+4 < P; appr_mask[k]=0 iff k < A. Registered outputs only; no combinational path from request to masks.
- o_cfg_ready = 1 only in IDLE and when i_cfg_flush=0.
- IDLE: on handshake, if P<4, P>16 or A>8: pulse o_cfg_err next cycle, discard the request, stay IDLE. Otherwise capture P and A in shadow registers. Go to DRAIN if i_array_idle=1, else WAIT.
- WAIT: o_busy=1, o_stall=0. On i_tile_last: go to DRAIN. If i_array_idle=1 in the same cycle, i_array_idle has priority and takes the same transition.
- DRAIN: o_stall=1. A counter loads PIPE_DEPTH-1 and decrements; at 0 go to APPLY. With PIPE_DEPTH=0, DRAIN is skipped (WAIT/IDLE go straight to APPLY).
- APPLY (one cycle): load masks and cur_* from shadow. Pulse o_cfg_applied (registered; visible the cycle masks change). o_stall=1 this cycle, 0 next. Return to IDLE.
- Request to apply latency with array idle: handshake cycle + PIPE_DEPTH + 1 cycles.
- i_cfg_flush in WAIT: return to IDLE with masks unchanged and no pulse. In DRAIN/APPLY it is ignored (switch completes). In IDLE it blocks acceptance.
- An identical config (same P and A) still runs the full sequence and pulses o_cfg_applied.
- Reset mid-switch: immediate return to reset values; the shadow config is lost.

Optional Feature:
MUL_CFG_STATS_EN:
- Defined: o_applied_cnt increments on each o_cfg_applied; o_err_cnt increments on each o_cfg_err. Both are 16-bit saturating (hold at 16'hFFFF) and cleared only by reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset, then request P=8,A=3 with i_array_idle=1, PIPE_DEPTH=3 -> o_res_mask=12'h00F, o_appr_mask=8'hF8, o_cfg_applied pulses at handshake+4 cycles, o_stall high exactly 4 cycles.
- Array busy, request P=16,A=0 -> masks unchanged and o_stall=0 until i_tile_last; then 12'hFFF/8'hFF applied after the drain.
- Illegal requests P=3, P=17, A=9 -> one o_cfg_err pulse each; masks and o_cur_* unchanged; o_err_cnt=3 with MUL_CFG_STATS_EN.
- Request P=4,A=8 then i_cfg_flush while in WAIT -> IDLE, no o_cfg_applied, masks still the previous config; the next request is accepted immediately.
- Request P=12,A=2 with i_tile_last and i_array_idle high together -> single DRAIN entry; o_res_mask=12'h0FF, o_appr_mask=8'hFC.
- Assert i_rstn low during DRAIN -> outputs return to reset values asynchronously; o_stall drops without waiting for a clock edge.

Source files
------------

// File: rtl/mul_approx_cfg_ctrl.sv
// mul_approx_cfg_ctrl
// Configuration sequencer for the systolic array's approximate signed
// multipliers. A precision/approximation request (P, A) is accepted over a
// valid/ready handshake and held in a shadow register. The new masks are
// applied only at a tile boundary, after the in-flight MACs have drained, so
// that every product in a tile sees one consistent configuration.
//
// Optional build macro: MUL_CFG_STATS_EN
//   defined   : 16-bit saturating counters of applied configs and rejected requests
//   undefined : o_applied_cnt / o_err_cnt tied to zero, no counter flops
//
// Ports
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_cfg_valid          request valid
//   o_cfg_ready          request accepted when valid & ready
//   i_cfg_prec           requested result precision P (legal 4..MAC_OUT_WIDTH)
//   i_cfg_appr           requested truncated LSB columns A (legal 0..N_BIT_APPR)
//   i_tile_last          pulse: last operand of the current tile issued
//   i_array_idle         array holds no tile
//   i_cfg_flush          abort a pending (waiting) request
//   o_res_mask           result mask to every multiplier
//   o_appr_mask          approximation mask to every multiplier
//   o_stall              hold the array feeder
//   o_busy               sequencer not idle
//   o_cfg_applied        one-cycle pulse, high in the cycle the new masks appear
//   o_cfg_err            one-cycle pulse after an illegal request
//   o_cur_prec           active P
//   o_cur_appr           active A
//   o_applied_cnt        applied-config count (stats build only)
//   o_err_cnt            illegal-request count (stats build only)
//
// state  | meaning
// IDLE   | ready for a request; masks hold the active config
// WAIT   | request captured, waiting for the current tile to finish
// DRAIN  | feeder stalled while in-flight products leave the array
// APPLY  | new masks visible this cycle, o_cfg_applied high

module mul_approx_cfg_ctrl #(
  parameter int MAC_OUT_WIDTH = 16,
  parameter int N_BIT_RES     = 12,
  parameter int N_BIT_APPR    = 8,
  parameter int PIPE_DEPTH    = 3,
  parameter int PREC_W        = 5,
  parameter int APPR_W        = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [PREC_W-1:0]     i_cfg_prec,
  input  logic [APPR_W-1:0]     i_cfg_appr,
  input  logic                  i_tile_last,
  input  logic                  i_array_idle,
  input  logic                  i_cfg_flush,
  output logic [N_BIT_RES-1:0]  o_res_mask,
  output logic [N_BIT_APPR-1:0] o_appr_mask,
  output logic                  o_stall,
  output logic                  o_busy,
  output logic                  o_cfg_applied,
  output logic                  o_cfg_err,
  output logic [PREC_W-1:0]     o_cur_prec,
  output logic [APPR_W-1:0]     o_cur_appr,
  output logic [15:0]           o_applied_cnt,
  output logic [15:0]           o_err_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_APPLY = 2'd3;

  // With no pipeline to drain the sequencer jumps straight to APPLY.
  localparam logic [1:0] ST_AFTER_WAIT = (PIPE_DEPTH == 0) ? ST_APPLY : ST_DRAIN;

  localparam int CNT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (PIPE_DEPTH > 0) ? CNT_W'(PIPE_DEPTH - 1) : '0;

  localparam logic [PREC_W-1:0] PREC_MIN = PREC_W'(4);
  localparam logic [PREC_W-1:0] PREC_MAX = PREC_W'(MAC_OUT_WIDTH);
  localparam logic [APPR_W-1:0] APPR_MAX = APPR_W'(N_BIT_APPR);
  localparam logic [PREC_W-1:0] PREC_RST = PREC_W'(MAC_OUT_WIDTH);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [CNT_W-1:0]      r_drain_cnt;
  logic [PREC_W-1:0]     r_shd_prec;
  logic [APPR_W-1:0]     r_shd_appr;
  logic [N_BIT_RES-1:0]  r_res_mask;
  logic [N_BIT_APPR-1:0] r_appr_mask;
  logic [PREC_W-1:0]     r_cur_prec;
  logic [APPR_W-1:0]     r_cur_appr;
  logic                  r_applied;
  logic                  r_err;

  logic                  w_hs;
  logic                  w_req_legal;
  logic [PREC_W-1:0]     w_src_prec;
  logic [APPR_W-1:0]     w_src_appr;

  function automatic logic [N_BIT_RES-1:0] f_res_mask(input logic [PREC_W-1:0] p);
    logic [N_BIT_RES-1:0] m;
    for (int k = 0; k < N_BIT_RES; k++) begin
      m[k] = ((k + 4) < int'(p));
    end
    return m;
  endfunction

  function automatic logic [N_BIT_APPR-1:0] f_appr_mask(input logic [APPR_W-1:0] a);
    logic [N_BIT_APPR-1:0] m;
    for (int k = 0; k < N_BIT_APPR; k++) begin
      m[k] = !(k < int'(a));
    end
    return m;
  endfunction

  assign o_cfg_ready = (r_state == ST_IDLE) && !i_cfg_flush;
  assign w_hs        = i_cfg_valid && o_cfg_ready;
  assign w_req_legal = (i_cfg_prec >= PREC_MIN) && (i_cfg_prec <= PREC_MAX) &&
                       (i_cfg_appr <= APPR_MAX);

  // The shadow is only written at the handshake edge, so a zero-depth switch
  // straight out of IDLE must take the request fields directly.
  assign w_src_prec = (r_state == ST_IDLE) ? i_cfg_prec : r_shd_prec;
  assign w_src_appr = (r_state == ST_IDLE) ? i_cfg_appr : r_shd_appr;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs && w_req_legal) begin
          w_next_state = i_array_idle ? ST_AFTER_WAIT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_cfg_flush) begin
          w_next_state = ST_IDLE;
        end else if (i_tile_last || i_array_idle) begin
          w_next_state = ST_AFTER_WAIT;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_next_state = ST_APPLY;
        end
      end
      ST_APPLY: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      r_shd_prec  <= PREC_RST;
      r_shd_appr  <= '0;
      r_res_mask  <= '1;
      r_appr_mask <= '1;
      r_cur_prec  <= PREC_RST;
      r_cur_appr  <= '0;
      r_applied   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if ((w_next_state == ST_DRAIN) && (r_state != ST_DRAIN)) begin
        r_drain_cnt <= CNT_LOAD;
      end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
        r_drain_cnt <= r_drain_cnt - 1'b1;
      end

      if ((r_state == ST_IDLE) && w_hs && w_req_legal) begin
        r_shd_prec <= i_cfg_prec;
        r_shd_appr <= i_cfg_appr;
      end

      // Masks are loaded on the edge entering APPLY so that the pulse and the
      // new masks share the APPLY cycle.
      r_applied <= (w_next_state == ST_APPLY);
      if (w_next_state == ST_APPLY) begin
        r_res_mask  <= f_res_mask(w_src_prec);
        r_appr_mask <= f_appr_mask(w_src_appr);
        r_cur_prec  <= w_src_prec;
        r_cur_appr  <= w_src_appr;
      end

      r_err <= w_hs && !w_req_legal;
    end
  end

  // Derived from the state register so that reset drops them immediately.
  assign o_stall       = (r_state == ST_DRAIN) || (r_state == ST_APPLY);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_res_mask    = r_res_mask;
  assign o_appr_mask   = r_appr_mask;
  assign o_cur_prec    = r_cur_prec;
  assign o_cur_appr    = r_cur_appr;
  assign o_cfg_applied = r_applied;
  assign o_cfg_err     = r_err;

`ifdef MUL_CFG_STATS_EN
  logic [15:0] r_applied_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_applied_cnt <= '0;
      r_err_cnt     <= '0;
    end else begin
      if (r_applied && (r_applied_cnt != 16'hFFFF)) begin
        r_applied_cnt <= r_applied_cnt + 16'd1;
      end
      if (r_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign o_applied_cnt = r_applied_cnt;
  assign o_err_cnt     = r_err_cnt;
`else
  assign o_applied_cnt = 16'd0;
  assign o_err_cnt     = 16'd0;
`endif

endmodule
